// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation sequencer.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADNG,
    RAMP_UP,
    RAMP_DN_SLOW,
    RAMP_DN_FAST
  } nav_state_t;

  localparam logic [10:0] STEP_FAST    = 11'h018;
  localparam logic [10:0] STEP_SLOW    = 11'h002;
  localparam logic [10:0] MAX_SPD_DFLT = 11'h2A0;

  localparam int unsigned DEC_SLOW_MUL = 2;
  localparam int unsigned DEC_FAST_MUL = 8;

endpackage

// File: rtl/nav_spd_ramp.sv
// Saturating forward-speed register: ramps up to MAX_SPD, ramps down to 0,
// updating only on heading-sample strobes (clear is immediate).
module nav_spd_ramp
  import nav_pkg::*;
#(
  parameter logic [10:0] STEP    = STEP_FAST,
  parameter logic [10:0] MAX_SPD = MAX_SPD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  input  logic        dec_slow,
  input  logic        dec_fast,
  input  logic        hdng_rdy,
  output logic [10:0] frwrd_spd
);

  localparam logic [10:0] DEC_S = 11'(STEP * DEC_SLOW_MUL);
  localparam logic [10:0] DEC_F = 11'(STEP * DEC_FAST_MUL);

  // 12-bit sum so the increment cannot wrap before saturation
  logic [11:0] sum;
  assign sum = {1'b0, frwrd_spd} + {1'b0, STEP};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frwrd_spd <= '0;
    end else if (clr) begin
      frwrd_spd <= '0;
    end else if (hdng_rdy) begin
      if (inc)
        frwrd_spd <= (sum > {1'b0, MAX_SPD}) ? MAX_SPD : sum[10:0];
      else if (dec_slow)
        frwrd_spd <= (frwrd_spd <= DEC_S) ? '0 : frwrd_spd - DEC_S;
      else if (dec_fast)
        frwrd_spd <= (frwrd_spd <= DEC_F) ? '0 : frwrd_spd - DEC_F;
    end
  end

endmodule

// File: rtl/nav_ctrl.sv
// Navigation sequencer: executes solver heading/move commands and returns
// a one-cycle mv_cmplt when each finishes.
module nav_ctrl
  import nav_pkg::*;
#(
  parameter bit          FAST_SIM = 1'b1,
  parameter logic [10:0] MAX_SPD  = MAX_SPD_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_rdy,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        mv_cmplt,
  output logic        moving,
  output logic        en_fusion,
  output logic [10:0] frwrd_spd
);

  localparam logic [10:0] STEP = FAST_SIM ? STEP_FAST : STEP_SLOW;

  nav_state_t state_q, state_d;
  logic       lft_opn_ff, rght_opn_ff;
  logic       lft_rise, rght_rise;
  logic       spd_clr, spd_inc, spd_dec_slow, spd_dec_fast;
  logic       spd_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lft_opn_ff  <= 1'b0;
      rght_opn_ff <= 1'b0;
    end else begin
      state_q     <= state_d;
      lft_opn_ff  <= lft_opn;
      rght_opn_ff <= rght_opn;
    end
  end

  assign lft_rise  = lft_opn & ~lft_opn_ff;
  assign rght_rise = rght_opn & ~rght_opn_ff;
  assign spd_zero  = (frwrd_spd == '0);
  assign en_fusion = (frwrd_spd > (MAX_SPD >> 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (strt_hdng)    state_d = HEADNG;
        else if (strt_mv) state_d = RAMP_UP;
      end
      HEADNG:
        if (at_hdng && hdng_rdy) state_d = IDLE;
      RAMP_UP: begin
        if (!frwrd_opn)
          state_d = RAMP_DN_FAST;
        else if ((stp_lft && lft_rise) || (stp_rght && rght_rise))
          state_d = RAMP_DN_SLOW;
      end
      RAMP_DN_SLOW: begin
        if (spd_zero)        state_d = IDLE;
        else if (!frwrd_opn) state_d = RAMP_DN_FAST;
      end
      RAMP_DN_FAST:
        if (spd_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mv_cmplt decodes the two "finished" transitions back to IDLE
  always_comb begin
    moving       = (state_q != IDLE);
    spd_clr      = ((state_q == IDLE) && strt_mv && !strt_hdng) || (state_q == HEADNG);
    spd_inc      = (state_q == RAMP_UP);
    spd_dec_slow = (state_q == RAMP_DN_SLOW);
    spd_dec_fast = (state_q == RAMP_DN_FAST);
    mv_cmplt     = ((state_q == HEADNG) && at_hdng && hdng_rdy) ||
                   (((state_q == RAMP_DN_SLOW) || (state_q == RAMP_DN_FAST)) && spd_zero);
  end

  nav_spd_ramp #(
    .STEP    (STEP),
    .MAX_SPD (MAX_SPD)
  ) u_spd_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (spd_clr),
    .inc       (spd_inc),
    .dec_slow  (spd_dec_slow),
    .dec_fast  (spd_dec_fast),
    .hdng_rdy  (hdng_rdy),
    .frwrd_spd (frwrd_spd)
  );

endmodule
